// File: rtl/ras_ckpt_fifo_if.sv
// Bundle between the fetch predictor / branch resolution unit and the RAS.
// Master drives requests, slave (the RAS) returns pop data and status.
interface ras_ckpt_fifo_if #(
    parameter int NumRasEntries  = 8,
    parameter int NumCheckpoints = 4,
    parameter int DatapathWidth  = 32,
    parameter int RasCntWidth    = $clog2(NumRasEntries + 1),
    parameter int CkptPtrWidth   = $clog2(NumCheckpoints),
    parameter int CkptCntWidth   = $clog2(NumCheckpoints + 1)
);
    logic                     flush_i;
    logic                     push_i;
    logic [DatapathWidth-1:0] push_pc_i;
    logic                     pop_i;
    logic                     pop_valid_o;
    logic [DatapathWidth-1:0] pop_pc_o;
    logic                     ckpt_alloc_i;
    logic                     ckpt_alloc_ready_o;
    logic [CkptPtrWidth-1:0]  ckpt_alloc_id_o;
    logic                     ckpt_release_i;
    logic                     ckpt_restore_i;
    logic [CkptPtrWidth-1:0]  ckpt_restore_id_i;
    logic [RasCntWidth-1:0]   count_o;
    logic                     empty_o;
    logic                     full_o;
    logic [CkptCntWidth-1:0]  ckpt_count_o;

    modport master (
        output flush_i, push_i, push_pc_i, pop_i,
        output ckpt_alloc_i, ckpt_release_i,
        output ckpt_restore_i, ckpt_restore_id_i,
        input  pop_valid_o, pop_pc_o,
        input  ckpt_alloc_ready_o, ckpt_alloc_id_o,
        input  count_o, empty_o, full_o, ckpt_count_o
    );

    modport slave (
        input  flush_i, push_i, push_pc_i, pop_i,
        input  ckpt_alloc_i, ckpt_release_i,
        input  ckpt_restore_i, ckpt_restore_id_i,
        output pop_valid_o, pop_pc_o,
        output ckpt_alloc_ready_o, ckpt_alloc_id_o,
        output count_o, empty_o, full_o, ckpt_count_o
    );
endinterface

// File: rtl/ras_ckpt_fifo.sv
// Return address stack with a circular FIFO of checkpoints for mispredict
// recovery. Define RAS_SATURATE_EN to drop pushes when full instead of wrapping.
module ras_ckpt_fifo #(
    parameter int NumRasEntries  = 8,
    parameter int NumCheckpoints = 4,
    parameter int DatapathWidth  = 32,
    parameter int RasPtrWidth    = $clog2(NumRasEntries),
    parameter int RasCntWidth    = $clog2(NumRasEntries + 1),
    parameter int CkptPtrWidth   = $clog2(NumCheckpoints),
    parameter int CkptCntWidth   = $clog2(NumCheckpoints + 1)
) (
    input logic           clk_i,
    input logic           rst_i,
    ras_ckpt_fifo_if.slave bus
);
    localparam logic [RasCntWidth-1:0]  RasFull  = RasCntWidth'(NumRasEntries);
    localparam logic [CkptCntWidth-1:0] CkptFull = CkptCntWidth'(NumCheckpoints);

    logic [DatapathWidth-1:0] entry_q [NumRasEntries];
    logic [RasPtrWidth-1:0]   tos_q;
    logic [RasCntWidth-1:0]   count_q;

    logic [RasPtrWidth-1:0]   ck_tos_q [NumCheckpoints];
    logic [RasCntWidth-1:0]   ck_cnt_q [NumCheckpoints];
    logic [DatapathWidth-1:0] ck_val_q [NumCheckpoints];
    logic [CkptPtrWidth-1:0]  head_q;
    logic [CkptPtrWidth-1:0]  tail_q;
    logic [CkptCntWidth-1:0]  ccnt_q;

    logic [CkptPtrWidth-1:0]  rst_off;
    logic                     restore_hit;
    logic                     restore_ok;
    logic                     pop_fire;
    logic                     rel_fire;
    logic                     alloc_fire;

    logic [RasPtrWidth-1:0]   tos_d;
    logic [RasCntWidth-1:0]   count_d;
    logic                     wr_en;
    logic [RasPtrWidth-1:0]   wr_idx;
    logic [DatapathWidth-1:0] wr_data;

    logic [CkptPtrWidth-1:0]  head_d;
    logic [CkptPtrWidth-1:0]  tail_d;
    logic [CkptCntWidth-1:0]  ccnt_d;
    logic [CkptPtrWidth-1:0]  ck_span;
    logic                     ck_wr;

    // A restore only counts if its ID lies inside the allocated window.
    always_comb begin
        rst_off     = bus.ckpt_restore_id_i - head_q;
        restore_hit = CkptCntWidth'(rst_off) < ccnt_q;
        restore_ok  = bus.ckpt_restore_i && restore_hit && !bus.flush_i;
        pop_fire    = bus.pop_i && (count_q != '0)
                      && !bus.flush_i && !restore_ok;
        rel_fire    = bus.ckpt_release_i && (ccnt_q != '0);
        alloc_fire  = bus.ckpt_alloc_i && (ccnt_q != CkptFull);
    end

    assign bus.pop_valid_o        = pop_fire;
    assign bus.pop_pc_o           = pop_fire ? entry_q[tos_q] : '0;
    assign bus.count_o            = count_q;
    assign bus.empty_o            = (count_q == '0);
    assign bus.full_o             = (count_q == RasFull);
    assign bus.ckpt_count_o       = ccnt_q;
    assign bus.ckpt_alloc_ready_o = (ccnt_q != CkptFull);
    assign bus.ckpt_alloc_id_o    = tail_q;

    // Stack pointer/count update and the single entry write for this cycle.
    always_comb begin
        tos_d   = tos_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = tos_q;
        wr_data = bus.push_pc_i;
        if (bus.flush_i) begin
            tos_d   = '0;
            count_d = '0;
        end else if (restore_ok) begin
            tos_d   = ck_tos_q[bus.ckpt_restore_id_i];
            count_d = ck_cnt_q[bus.ckpt_restore_id_i];
            wr_en   = 1'b1;
            wr_idx  = ck_tos_q[bus.ckpt_restore_id_i];
            wr_data = ck_val_q[bus.ckpt_restore_id_i];
        end else if (bus.push_i && pop_fire) begin
            wr_en = 1'b1;
        end else if (bus.push_i) begin
`ifdef RAS_SATURATE_EN
            if (count_q != RasFull) begin
                tos_d   = tos_q + RasPtrWidth'(1);
                count_d = count_q + RasCntWidth'(1);
                wr_en   = 1'b1;
                wr_idx  = tos_q + RasPtrWidth'(1);
            end
`else
            tos_d  = tos_q + RasPtrWidth'(1);
            wr_en  = 1'b1;
            wr_idx = tos_q + RasPtrWidth'(1);
            if (count_q != RasFull) begin
                count_d = count_q + RasCntWidth'(1);
            end
`endif
        end else if (pop_fire) begin
            tos_d   = tos_q - RasPtrWidth'(1);
            count_d = count_q - RasCntWidth'(1);
        end
    end

    // Checkpoint FIFO pointers; restore truncates the tail back to the ID.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        ccnt_d  = ccnt_q;
        ck_span = '0;
        ck_wr   = 1'b0;
        if (bus.flush_i) begin
            head_d = '0;
            tail_d = '0;
            ccnt_d = '0;
        end else if (restore_ok) begin
            head_d  = head_q + CkptPtrWidth'(rel_fire);
            tail_d  = bus.ckpt_restore_id_i;
            ck_span = bus.ckpt_restore_id_i - head_d;
            ccnt_d  = CkptCntWidth'(ck_span);
        end else begin
            ck_wr  = alloc_fire;
            head_d = head_q + CkptPtrWidth'(rel_fire);
            tail_d = tail_q + CkptPtrWidth'(alloc_fire);
            ccnt_d = ccnt_q + CkptCntWidth'(alloc_fire)
                     - CkptCntWidth'(rel_fire);
        end
    end

    // Stack state and entry storage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tos_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < NumRasEntries; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            tos_q   <= tos_d;
            count_q <= count_d;
            if (wr_en) begin
                entry_q[wr_idx] <= wr_data;
            end
        end
    end

    // Checkpoint pointers and snapshot of the pre-update stack top.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
            ccnt_q <= '0;
            for (int i = 0; i < NumCheckpoints; i++) begin
                ck_tos_q[i] <= '0;
                ck_cnt_q[i] <= '0;
                ck_val_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            ccnt_q <= ccnt_d;
            if (ck_wr) begin
                ck_tos_q[tail_q] <= tos_q;
                ck_cnt_q[tail_q] <= count_q;
                ck_val_q[tail_q] <= entry_q[tos_q];
            end
        end
    end

    a_restore_alloc : assert property (
        @(posedge clk_i) disable iff (rst_i)
        (bus.ckpt_restore_i && !bus.flush_i) |-> restore_hit
    );

    a_restore_head : assert property (
        @(posedge clk_i) disable iff (rst_i)
        (bus.ckpt_restore_i && bus.ckpt_release_i && !bus.flush_i)
        |-> (bus.ckpt_restore_id_i != head_q)
    );
endmodule
